// File: rtl/lpc_io_dispatcher.sv
// LPC I/O request dispatcher: decodes the peripheral's I/O address onto one of
// up to four internal targets, strobes it, and waits for an ack with timeout.
module lpc_io_dispatcher #(
    parameter int          NUM_TGT     = 4,
    parameter logic [63:0] TGT_BASE    = 64'h0080_03F8_0060_002E,
    parameter logic [63:0] TGT_MASK    = 64'hFFFF_FFF8_FFFB_FFFE,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic [15:0]          periph_addr_i,
    input  logic [7:0]           periph_wdata_i,
    input  logic                 periph_wr_req_i,
    input  logic                 periph_rd_req_i,
    output logic                 periph_wr_done_o,
    output logic [7:0]           periph_rdata_o,
    output logic                 periph_rd_valid_o,
    output logic [NUM_TGT-1:0]   tgt_sel_o,
    output logic [15:0]          tgt_addr_o,
    output logic [7:0]           tgt_wdata_o,
    output logic                 tgt_wr_o,
    output logic                 tgt_rd_o,
    input  logic [NUM_TGT-1:0]   tgt_ack_i,
    input  logic [8*NUM_TGT-1:0] tgt_rdata_i,
    output logic                 err_o,
    input  logic                 err_clr_i,
    output logic [7:0]           timeout_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t               state_reg;
    logic                 is_wr_reg;
    logic [7:0]           wait_cnt_reg;
    logic [NUM_TGT-1:0]   addr_match;
    logic [NUM_TGT-1:0]   pick_sel;
    logic                 pick_hit;
    logic                 ack_sel;
    logic [7:0]           rdata_sel;
    logic                 req_live;

    generate
        for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_match
            assign addr_match[gi] =
                ((periph_addr_i & TGT_MASK[16*gi +: 16]) ==
                 (TGT_BASE[16*gi +: 16] & TGT_MASK[16*gi +: 16]));
        end
    endgenerate

    // Scanning downwards leaves the lowest matching index as the winner.
    always_comb begin
        pick_sel = '0;
        pick_hit = 1'b0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (addr_match[i]) begin
                pick_sel    = '0;
                pick_sel[i] = 1'b1;
                pick_hit    = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_sel = 8'h00;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (tgt_sel_o[i]) rdata_sel = tgt_rdata_i[8*i +: 8];
        end
    end

    assign ack_sel  = |(tgt_ack_i & tgt_sel_o);
    assign req_live = is_wr_reg ? periph_wr_req_i : periph_rd_req_i;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_reg         <= S_IDLE;
            is_wr_reg         <= 1'b0;
            wait_cnt_reg      <= 8'h00;
            periph_wr_done_o  <= 1'b0;
            periph_rdata_o    <= 8'h00;
            periph_rd_valid_o <= 1'b0;
            tgt_sel_o         <= '0;
            tgt_addr_o        <= 16'h0000;
            tgt_wdata_o       <= 8'h00;
            tgt_wr_o          <= 1'b0;
            tgt_rd_o          <= 1'b0;
            err_o             <= 1'b0;
            timeout_cnt_o     <= 8'h00;
        end else begin
            tgt_wr_o          <= 1'b0;
            tgt_rd_o          <= 1'b0;
            periph_wr_done_o  <= 1'b0;
            periph_rd_valid_o <= 1'b0;
            // A timeout set further down overrides this clear on the same edge.
            if (err_clr_i) err_o <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (periph_wr_req_i || periph_rd_req_i) begin
                        is_wr_reg  <= periph_wr_req_i;
                        tgt_addr_o <= periph_addr_i;
                        if (periph_wr_req_i) tgt_wdata_o <= periph_wdata_i;
                        if (pick_hit) begin
                            tgt_sel_o <= pick_sel;
                            tgt_wr_o  <= periph_wr_req_i;
                            tgt_rd_o  <= !periph_wr_req_i;
                            state_reg <= S_ISSUE;
                        end else begin
                            // Unclaimed: writes vanish, reads float high.
                            periph_wr_done_o  <= periph_wr_req_i;
                            periph_rd_valid_o <= !periph_wr_req_i;
                            if (!periph_wr_req_i) periph_rdata_o <= 8'hFF;
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt_reg <= 8'h00;
                    if (!req_live) begin
                        tgt_sel_o <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req_live) begin
                        tgt_sel_o <= '0;
                        state_reg <= S_IDLE;
                    end else if (ack_sel) begin
                        periph_wr_done_o  <= is_wr_reg;
                        periph_rd_valid_o <= !is_wr_reg;
                        if (!is_wr_reg) periph_rdata_o <= rdata_sel;
                        state_reg <= S_DONE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        periph_wr_done_o  <= is_wr_reg;
                        periph_rd_valid_o <= !is_wr_reg;
                        if (!is_wr_reg) periph_rdata_o <= 8'hFF;
                        err_o <= 1'b1;
                        if (timeout_cnt_o != 8'hFF) timeout_cnt_o <= timeout_cnt_o + 8'd1;
                        state_reg <= S_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                S_DONE: begin
                    tgt_sel_o <= '0;
                    state_reg <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!req_live) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_io_dispatcher.sv
// Self-checking bench for lpc_io_dispatcher: directed scenarios followed by
// randomized transactions, checked against a transaction-level model.
module tb_lpc_io_dispatcher;

    localparam int          NUM_TGT = 4;
    localparam logic [63:0] BASE    = 64'h0080_03F8_0060_002E;
    localparam logic [63:0] MASK    = 64'hFFFF_FFF8_FFFB_FFFE;
    localparam int          TMO     = 64;

    logic                 clk_i = 1'b0;
    logic                 nrst_i = 1'b0;
    logic [15:0]          periph_addr_i = '0;
    logic [7:0]           periph_wdata_i = '0;
    logic                 periph_wr_req_i = 1'b0;
    logic                 periph_rd_req_i = 1'b0;
    logic                 periph_wr_done_o;
    logic [7:0]           periph_rdata_o;
    logic                 periph_rd_valid_o;
    logic [NUM_TGT-1:0]   tgt_sel_o;
    logic [15:0]          tgt_addr_o;
    logic [7:0]           tgt_wdata_o;
    logic                 tgt_wr_o;
    logic                 tgt_rd_o;
    logic [NUM_TGT-1:0]   tgt_ack_i = '0;
    logic [8*NUM_TGT-1:0] tgt_rdata_i = '0;
    logic                 err_o;
    logic                 err_clr_i = 1'b0;
    logic [7:0]           timeout_cnt_o;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    logic       exp_err   = 1'b0;
    logic [7:0] exp_tcnt  = 8'h00;
    logic [7:0] exp_rdata = 8'h00;
    bit         keep_rd   = 1'b0;
    bit         clr_hold  = 1'b0;

    lpc_io_dispatcher #(
        .NUM_TGT(NUM_TGT), .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk_i), .nrst_i(nrst_i),
        .periph_addr_i(periph_addr_i), .periph_wdata_i(periph_wdata_i),
        .periph_wr_req_i(periph_wr_req_i), .periph_rd_req_i(periph_rd_req_i),
        .periph_wr_done_o(periph_wr_done_o), .periph_rdata_o(periph_rdata_o),
        .periph_rd_valid_o(periph_rd_valid_o), .tgt_sel_o(tgt_sel_o),
        .tgt_addr_o(tgt_addr_o), .tgt_wdata_o(tgt_wdata_o),
        .tgt_wr_o(tgt_wr_o), .tgt_rd_o(tgt_rd_o), .tgt_ack_i(tgt_ack_i),
        .tgt_rdata_i(tgt_rdata_i), .err_o(err_o), .err_clr_i(err_clr_i),
        .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest-index window that claims the address, -1 if none.
    function automatic int decode(input logic [15:0] a);
        logic [15:0] b, m;
        for (int i = 0; i < NUM_TGT; i++) begin
            b = BASE[16*i +: 16];
            m = MASK[16*i +: 16];
            if ((a & m) == (b & m)) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_TGT-1:0] onehot(input int idx);
        logic [NUM_TGT-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr_done"}, 32'(periph_wr_done_o), 32'd0);
        chk({tag, "_rd_valid"}, 32'(periph_rd_valid_o), 32'd0);
        chk({tag, "_sel"}, 32'(tgt_sel_o), 32'd0);
    endtask

    // Full transaction; ack_dly = WAIT cycle index of the ack (>= TMO: never).
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                           input int ack_dly, input logic [7:0] trd, input bit noise,
                           input int hold);
        int idx, d;
        bit tmo;
        logic [NUM_TGT-1:0] oh;
        idx = decode(addr);
        oh  = onehot(idx);
        tmo = (idx >= 0) && (ack_dly >= TMO);
        if (idx < 0)           d = 0;
        else if (ack_dly < TMO) d = 2 + ack_dly;
        else                   d = 1 + TMO;

        @(negedge clk_i);
        periph_addr_i  = addr;
        periph_wdata_i = wd;
        tgt_rdata_i    = $urandom;
        if (idx >= 0) tgt_rdata_i[8*idx +: 8] = trd;
        if (wr) periph_wr_req_i = 1'b1; else periph_rd_req_i = 1'b1;
        if (keep_rd) periph_rd_req_i = 1'b1;
        if (clr_hold) err_clr_i = 1'b1;

        for (int e = 0; e <= d; e++) begin
            if (e > 0) begin
                @(negedge clk_i);
                tgt_ack_i = '0;
                if (idx >= 0 && e >= 2 && (e - 2) == ack_dly) tgt_ack_i = oh;
                else if (noise) tgt_ack_i = (e == 1) ? oh : ~oh;
            end
            @(posedge clk_i); #1;
            chk("wr_done", 32'(periph_wr_done_o), 32'(wr && e == d));
            chk("rd_valid", 32'(periph_rd_valid_o), 32'(!wr && e == d));
            chk("wr_strobe", 32'(tgt_wr_o), 32'(wr && idx >= 0 && e == 0));
            chk("rd_strobe", 32'(tgt_rd_o), 32'(!wr && idx >= 0 && e == 0));
            chk("sel", 32'(tgt_sel_o), 32'(oh));
        end

        if (!wr) exp_rdata = (idx >= 0 && !tmo) ? trd : 8'hFF;
        if (clr_hold) exp_err = tmo; else exp_err = exp_err | tmo;
        if (tmo && exp_tcnt != 8'hFF) exp_tcnt = exp_tcnt + 8'd1;
        chk("tgt_addr", 32'(tgt_addr_o), 32'(addr));
        if (wr) chk("tgt_wdata", 32'(tgt_wdata_o), 32'(wd));
        chk("rdata", 32'(periph_rdata_o), 32'(exp_rdata));
        chk("err", 32'(err_o), 32'(exp_err));
        chk("tcnt", 32'(timeout_cnt_o), 32'(exp_tcnt));
        $display("txn %s addr=%04h tgt=%0d ack_dly=%0d rdata=%02h err=%0d tcnt=%0d",
                 wr ? "WR" : "RD", addr, idx, ack_dly, periph_rdata_o, err_o, timeout_cnt_o);

        @(negedge clk_i);
        tgt_ack_i = '0;
        err_clr_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i); #1;
            check_idle_outputs("release_hold");
            @(negedge clk_i);
        end
        if (wr) periph_wr_req_i = 1'b0; else periph_rd_req_i = 1'b0;
        @(posedge clk_i); #1;
        check_idle_outputs("post_drop");
    endtask

    // Request dropped after k WAIT edges (k = -1: dropped during ISSUE).
    task automatic run_abort(input bit wr, input logic [15:0] addr, input int k, input bit pre);
        int idx;
        bit found;
        logic [NUM_TGT-1:0] oh;
        idx = decode(addr);
        oh  = onehot(idx);
        found = 1'b0;
        if (!pre) begin
            @(negedge clk_i);
            periph_addr_i = addr;
            if (wr) periph_wr_req_i = 1'b1; else periph_rd_req_i = 1'b1;
        end
        for (int n = 0; n < 4 && !found; n++) begin
            @(posedge clk_i); #1;
            found = wr ? tgt_wr_o : tgt_rd_o;
            if (!found) check_idle_outputs("abort_pre");
        end
        chk("abort_strobe_seen", 32'(found), 32'd1);
        chk("abort_sel", 32'(tgt_sel_o), 32'(oh));
        chk("abort_addr", 32'(tgt_addr_o), 32'(addr));
        for (int j = 0; j <= k; j++) begin
            @(posedge clk_i); #1;
            chk("abort_wait_pulse", 32'(periph_wr_done_o | periph_rd_valid_o), 32'd0);
            chk("abort_wait_sel", 32'(tgt_sel_o), 32'(oh));
        end
        @(negedge clk_i);
        if (wr) periph_wr_req_i = 1'b0; else periph_rd_req_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk_i); #1;
            check_idle_outputs("abort_after");
            chk("abort_strobes", 32'({tgt_wr_o, tgt_rd_o}), 32'd0);
        end
        chk("abort_err", 32'(err_o), 32'(exp_err));
        $display("abort %s addr=%04h tgt=%0d drop_after=%0d", wr ? "WR" : "RD", addr, idx, k);
    endtask

    initial begin
        logic [15:0] a, bb, mm;
        int r, dly;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_idle_outputs("reset");
        chk("reset_rdata", 32'(periph_rdata_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_tcnt", 32'(timeout_cnt_o), 32'd0);
        chk("reset_strobes", 32'({tgt_wr_o, tgt_rd_o}), 32'd0);
        @(negedge clk_i);
        nrst_i = 1'b1;

        // Write, ack in first WAIT cycle: pulse 2 edges after strobe edge
        run_txn(1'b1, 16'h0080, 8'hA5, 0, 8'h00, 1'b0, 1);
        // Read with ack after 5 WAIT cycles, stray acks, request held long
        run_txn(1'b0, 16'h03FD, 8'h00, 5, 8'h60, 1'b1, 4);
        // Unclaimed read
        run_txn(1'b0, 16'h1234, 8'h00, 0, 8'h00, 1'b0, 1);
        // Unclaimed write
        run_txn(1'b1, 16'h1234, 8'h3C, 0, 8'h00, 1'b0, 1);
        // Timeout on write
        run_txn(1'b1, 16'h002F, 8'h11, 1000, 8'h00, 1'b0, 1);
        @(negedge clk_i);
        err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        exp_err = 1'b0;
        chk("err_clr", 32'(err_o), 32'd0);
        chk("err_clr_tcnt", 32'(timeout_cnt_o), 32'(exp_tcnt));
        @(negedge clk_i);
        err_clr_i = 1'b0;

        // Write and read together: write first, read only after wr_req drops
        keep_rd = 1'b1;
        run_txn(1'b1, 16'h0060, 8'h5A, 2, 8'h00, 1'b0, 2);
        keep_rd = 1'b0;
        run_abort(1'b0, 16'h0060, 3, 1'b1);

        // Timeout with err_clr held: the set must win on the timeout edge
        clr_hold = 1'b1;
        run_txn(1'b0, 16'h0064, 8'h00, 1000, 8'h77, 1'b0, 1);
        clr_hold = 1'b0;
        // Ack on the last WAIT cycle beats the timeout
        run_txn(1'b0, 16'h03F8, 8'h00, TMO - 1, 8'hC3, 1'b0, 1);
        // Abort during ISSUE
        run_abort(1'b1, 16'h0080, -1, 1'b0);

        // Asynchronous reset while waiting on a target
        @(negedge clk_i);
        periph_addr_i = 16'h002E;
        periph_rd_req_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #3;
        nrst_i = 1'b0;
        #1;
        check_idle_outputs("arst");
        chk("arst_strobes", 32'({tgt_wr_o, tgt_rd_o}), 32'd0);
        chk("arst_addr", 32'(tgt_addr_o), 32'd0);
        chk("arst_rdata", 32'(periph_rdata_o), 32'd0);
        chk("arst_err", 32'(err_o), 32'd0);
        chk("arst_tcnt", 32'(timeout_cnt_o), 32'd0);
        exp_err = 1'b0;
        exp_tcnt = 8'h00;
        exp_rdata = 8'h00;
        periph_rd_req_i = 1'b0;
        @(negedge clk_i);
        nrst_i = 1'b1;
        run_txn(1'b0, 16'h002E, 8'h00, 1, 8'h9B, 1'b0, 1);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 4);
            if (r < NUM_TGT) begin
                bb = BASE[16*r +: 16];
                mm = MASK[16*r +: 16];
                a  = (bb & mm) | (16'($urandom) & ~mm);
            end else begin
                a = 16'($urandom);
            end
            r = $urandom_range(0, 9);
            if (r == 9)      dly = 1000;
            else if (r == 8) dly = TMO - 1;
            else             dly = r;
            run_txn(1'($urandom), a, 8'($urandom), dly, 8'($urandom),
                    1'($urandom), $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
